// File: rtl/cla3_4b_rr_arbiter.sv
// Round-robin arbiter sharing one 3-operand 4-bit carry-lookahead adder between NREQ requesters.
// Results and the producing requester ID are buffered in a 2-entry FIFO.
module cla3_4b_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_in1,
  input  logic [4*NREQ-1:0] req_in2,
  input  logic [4*NREQ-1:0] req_in3,
  input  logic [NREQ-1:0]   req_cin,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [3:0]        res_sum,
  output logic              res_cout_1,
  output logic              res_cout_2,
  output logic [IDW-1:0]    res_id,
  output logic              busy
);

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0]     count_q, count_d;
  logic           rd_ptr_q, wr_ptr_q;

  logic [3:0]     fifo_sum_q [2];
  logic           fifo_c1_q  [2];
  logic           fifo_c2_q  [2];
  logic [IDW-1:0] fifo_id_q  [2];

  logic           space;
  logic           found;
  logic [IDW-1:0] winner;
  logic           push;
  logic           pop;

  logic [3:0]     op1, op2, op3;
  logic           op_cin;

  logic [3:0]     csa_s, csa_c;
  logic [4:0]     cla_a, cla_b, gen, prop;
  logic [5:0]     carry;
  logic [5:0]     add_res;

  // Grant search: requesters at or above rr_ptr first, then wrap to the lowest index.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (IDW'(i) >= rr_ptr_q)) begin
        found  = 1'b1;
        winner = IDW'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i]) begin
        found  = 1'b1;
        winner = IDW'(i);
      end
    end
  end

  assign space = (count_q < 2'd2);
  assign push  = found && space && !rst;

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = push && (winner == IDW'(i));
    end
  end

  always_comb begin
    op1    = '0;
    op2    = '0;
    op3    = '0;
    op_cin = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        op1    = req_in1[4*i +: 4];
        op2    = req_in2[4*i +: 4];
        op3    = req_in3[4*i +: 4];
        op_cin = req_cin[i];
      end
    end
  end

  // 3:2 carry-save compression, then a 5-bit lookahead adder with cin as carry-in.
  always_comb begin
    csa_s = op1 ^ op2 ^ op3;
    csa_c = (op1 & op2) | (op1 & op3) | (op2 & op3);
    cla_a = {1'b0, csa_s};
    cla_b = {csa_c, 1'b0};
    gen   = cla_a & cla_b;
    prop  = cla_a ^ cla_b;

    carry[0] = op_cin;
    carry[1] = gen[0] | (prop[0] & op_cin);
    carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & op_cin);
    carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
             | (prop[2] & prop[1] & prop[0] & op_cin);
    carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0])
             | (prop[3] & prop[2] & prop[1] & prop[0] & op_cin);
    carry[5] = gen[4] | (prop[4] & gen[3]) | (prop[4] & prop[3] & gen[2])
             | (prop[4] & prop[3] & prop[2] & gen[1])
             | (prop[4] & prop[3] & prop[2] & prop[1] & gen[0])
             | (prop[4] & prop[3] & prop[2] & prop[1] & prop[0] & op_cin);

    add_res = {carry[5], prop ^ carry[4:0]};
  end

  always_comb begin
    if (winner == IDW'(NREQ - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = winner + IDW'(1);
    end
  end

  assign res_valid = (count_q != 2'd0);
  assign pop       = res_valid && res_ready;
  assign busy      = res_valid || (|req_valid);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        rr_ptr_q <= rr_ptr_d;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Payload needs no reset: it is only visible through count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_sum_q[wr_ptr_q] <= add_res[3:0];
      fifo_c1_q[wr_ptr_q]  <= add_res[4];
      fifo_c2_q[wr_ptr_q]  <= add_res[5];
      fifo_id_q[wr_ptr_q]  <= winner;
    end
  end

  always_comb begin
    res_sum    = '0;
    res_cout_1 = 1'b0;
    res_cout_2 = 1'b0;
    res_id     = '0;
    if (res_valid) begin
      res_sum    = fifo_sum_q[rd_ptr_q];
      res_cout_1 = fifo_c1_q[rd_ptr_q];
      res_cout_2 = fifo_c2_q[rd_ptr_q];
      res_id     = fifo_id_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_cla3_4b_rr_arbiter.sv
// Self-checking bench: arithmetic vector table, scoreboard of accepted operations,
// and hand-written handshake sequences.
module tb_cla3_4b_rr_arbiter;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready;
  logic [15:0] req_in1, req_in2, req_in3;
  logic [3:0]  req_cin;
  logic        res_valid, res_ready;
  logic [3:0]  res_sum;
  logic        res_cout_1, res_cout_2;
  logic [1:0]  res_id;
  logic        busy;

  always #5 clk = ~clk;

  cla3_4b_rr_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_in1    (req_in1),
    .req_in2    (req_in2),
    .req_in3    (req_in3),
    .req_cin    (req_cin),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_cout_1 (res_cout_1),
    .res_cout_2 (res_cout_2),
    .res_id     (res_id),
    .busy       (busy)
  );

  typedef struct {
    int a, b, c, ci;
    int sum, c1, c2;
  } vec_t;

  typedef struct {
    int val;
    int id;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  int   n_acc    = 0;
  exp_t sb[$];
  int   acc_log[$];
  int   pop_log[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic set_op(input int i, input int a, input int b, input int c, input int ci);
    req_in1[4*i +: 4] = 4'(a);
    req_in2[4*i +: 4] = 4'(b);
    req_in3[4*i +: 4] = 4'(c);
    req_cin[i]        = ci[0];
  endtask

  // Scoreboard update at the sampling point: pops before pushes, reset flushes.
  task automatic observe();
    exp_t e;
    int   act;
    if (rst) begin
      sb.delete();
      return;
    end
    check("ready_onehot", $countones(req_ready) <= 1, 1);
    if (res_valid) check("cout_exclusive", res_cout_1 & res_cout_2, 0);
    if (res_valid && res_ready) begin
      pop_log.push_back(int'(res_id));
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: actual=result id %0d required=no result", res_id);
      end else begin
        e   = sb.pop_front();
        act = int'(res_id) * 64 + int'(res_cout_2) * 32 + int'(res_cout_1) * 16 + int'(res_sum);
        check("sb_result", act, e.id * 64 + e.val);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.id  = i;
        e.val = int'(req_in1[4*i +: 4]) + int'(req_in2[4*i +: 4]) + int'(req_in3[4*i +: 4])
              + int'(req_cin[i]);
        sb.push_back(e);
        acc_log.push_back(i);
        n_acc++;
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic close_cycle();
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    half();
    close_cycle();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    res_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{a: 0,  b: 0,  c: 0,  ci: 0, sum: 0,  c1: 0, c2: 0};
    vecs[1] = '{a: 15, b: 15, c: 15, ci: 1, sum: 14, c1: 0, c2: 1};
    vecs[2] = '{a: 15, b: 0,  c: 0,  ci: 1, sum: 0,  c1: 1, c2: 0};
    vecs[3] = '{a: 5,  b: 6,  c: 4,  ci: 0, sum: 15, c1: 0, c2: 0};
    vecs[4] = '{a: 10, b: 10, c: 10, ci: 0, sum: 14, c1: 1, c2: 0};
    vecs[5] = '{a: 15, b: 15, c: 2,  ci: 0, sum: 0,  c1: 0, c2: 1};
    vecs[6] = '{a: 9,  b: 8,  c: 7,  ci: 1, sum: 9,  c1: 1, c2: 0};
    vecs[7] = '{a: 15, b: 15, c: 15, ci: 0, sum: 13, c1: 0, c2: 1};

    rst       = 1'b1;
    req_valid = '0;
    req_in1   = '0;
    req_in2   = '0;
    req_in3   = '0;
    req_cin   = '0;
    res_ready = 1'b0;
    @(posedge clk);
    #1;
    tick();

    // Reset state
    half();
    check("rst_ready", req_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_fields", {res_sum, res_cout_1, res_cout_2, res_id}, 0);
    check("rst_busy_idle", busy, 0);
    close_cycle();
    req_valid = 4'b0101;
    half();
    check("rst_ready_held", req_ready, 0);
    check("rst_busy_req", busy, 1);
    close_cycle();
    req_valid = '0;
    rst       = 1'b0;
    tick();

    // Single operation from requester 2
    set_op(2, 15, 15, 15, 1);
    req_valid = 4'b0100;
    res_ready = 1'b1;
    half();
    check("single_ready", req_ready, 4'b0100);
    check("single_busy", busy, 1);
    close_cycle();
    req_valid = '0;
    half();
    check("single_valid", res_valid, 1);
    check("single_sum", res_sum, 14);
    check("single_c1", res_cout_1, 0);
    check("single_c2", res_cout_2, 1);
    check("single_id", res_id, 2);
    close_cycle();
    half();
    check("single_drained", res_valid, 0);
    close_cycle();

    // Arithmetic vector table through requester 0
    for (int v = 0; v < 8; v++) begin
      set_op(0, vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].ci);
      req_valid = 4'b0001;
      half();
      check($sformatf("vec%0d_ready", v), req_ready, 4'b0001);
      close_cycle();
      req_valid = '0;
      half();
      check($sformatf("vec%0d_sum", v), res_sum, vecs[v].sum);
      check($sformatf("vec%0d_c1", v), res_cout_1, vecs[v].c1);
      check($sformatf("vec%0d_c2", v), res_cout_2, vecs[v].c2);
      close_cycle();
    end

    // Round-robin with all requesters continuously valid
    do_reset();
    acc_log.delete();
    pop_log.delete();
    for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 2 * i, 3, i % 2);
    req_valid = 4'hf;
    res_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      half();
      check($sformatf("rr_ready%0d", c), req_ready, 4'b0001 << (c % 4));
      close_cycle();
    end
    req_valid = '0;
    tick();
    tick();
    check("rr_accepts", acc_log.size(), 12);
    check("rr_pops", pop_log.size(), 12);
    for (int k = 0; k < 12; k++) begin
      if (k < acc_log.size()) check($sformatf("rr_acc%0d", k), acc_log[k], k % 4);
      if (k < pop_log.size()) check($sformatf("rr_res_id%0d", k), pop_log[k], k % 4);
    end

    // Backpressure: two accepts fill the FIFO, then drain in order
    do_reset();
    set_op(0, 1, 2, 3, 0);
    set_op(1, 4, 5, 6, 1);
    req_valid = 4'b0011;
    res_ready = 1'b0;
    half();
    check("bp_ready0", req_ready, 4'b0001);
    close_cycle();
    half();
    check("bp_ready1", req_ready, 4'b0010);
    close_cycle();
    half();
    check("bp_full_ready", req_ready, 0);
    check("bp_full_valid", res_valid, 1);
    check("bp_head0", res_id, 0);
    close_cycle();
    half();
    check("bp_full_hold", req_ready, 0);
    close_cycle();
    res_ready = 1'b1;
    half();
    check("bp_pop_cycle_ready", req_ready, 0);
    check("bp_head0_sum", res_sum, 6);
    close_cycle();
    half();
    check("bp_resume_ready", req_ready, 4'b0001);
    check("bp_head1", res_id, 1);
    check("bp_head1_sum", res_sum, 0);
    check("bp_head1_c1", res_cout_1, 1);
    close_cycle();
    half();
    check("bp_ready_next", req_ready, 4'b0010);
    check("bp_head_new0", res_id, 0);
    close_cycle();
    req_valid = '0;
    tick();
    tick();

    // Simultaneous push and pop with one entry buffered
    do_reset();
    set_op(0, 3, 3, 3, 0);
    set_op(1, 7, 7, 7, 1);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    res_ready = 1'b1;
    half();
    check("pp_head0", res_id, 0);
    check("pp_head0_sum", res_sum, 9);
    check("pp_ready1", req_ready, 4'b0010);
    close_cycle();
    req_valid = '0;
    half();
    check("pp_valid", res_valid, 1);
    check("pp_head1", res_id, 1);
    check("pp_sum1", res_sum, 6);
    check("pp_c1", res_cout_1, 1);
    close_cycle();
    half();
    check("pp_empty", res_valid, 0);
    close_cycle();

    // Reset while full and requesters waiting
    do_reset();
    set_op(1, 1, 1, 1, 0);
    set_op(2, 2, 2, 2, 1);
    req_valid = 4'b0110;
    tick();
    tick();
    set_op(0, 2, 2, 2, 0);
    set_op(3, 5, 5, 5, 0);
    req_valid = 4'b1001;
    half();
    check("mr_full_ready", req_ready, 0);
    check("mr_full_valid", res_valid, 1);
    close_cycle();
    rst = 1'b1;
    half();
    check("mr_rst_ready", req_ready, 0);
    close_cycle();
    rst = 1'b0;
    half();
    check("mr_res_valid", res_valid, 0);
    check("mr_res_fields", {res_sum, res_cout_1, res_cout_2, res_id}, 0);
    check("mr_ready_lowest", req_ready, 4'b0001);
    close_cycle();
    req_valid = '0;
    res_ready = 1'b1;
    half();
    check("mr_result_id", res_id, 0);
    check("mr_result_sum", res_sum, 6);
    close_cycle();
    tick();

    // Exhaustive arithmetic through requester 0
    do_reset();
    n_acc     = 0;
    res_ready = 1'b1;
    req_valid = 4'b0001;
    for (int n = 0; n < 8192; n++) begin
      set_op(0, n[12:9], n[8:5], n[4:1], n[0]);
      tick();
    end
    req_valid = '0;
    tick();
    tick();
    check("exh_accepts", n_acc, 8192);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cla3_4b_rr_arbiter.md
# cla3_4b_rr_arbiter

Round-robin arbiter that shares one 3-operand 4-bit carry-lookahead adder (port-compatible with `carry_lookahead_adder_3_4bits`) between `NREQ` requesters. Each requester presents a `{in1, in2, in3, cin}` operation through a valid/ready handshake. The block grants one requester per cycle and evaluates the shared adder combinationally. It captures the 6-bit result plus the requester ID in a 2-entry output FIFO that drains over a second valid/ready handshake. It sits between operand-producing units (multiplier partial-product reducers) and the shared adder.

## Interface
Parameters:
- `NREQ`, 4, number of requesters; legal range 2..8.
- `IDW`, `$clog2(NREQ)`, requester ID width; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  `NREQ`  per-requester operation valid.
- `req_ready`  out  `NREQ`  per-requester accept; at most one bit high per cycle.
- `req_in1`  in  `4*NREQ`  operand 1; requester i occupies bits `[4i+3:4i]`.
- `req_in2`  in  `4*NREQ`  operand 2, same packing.
- `req_in3`  in  `4*NREQ`  operand 3, same packing.
- `req_cin`  in  `NREQ`  carry-in; bit i belongs to requester i.
- `res_valid`  out  1  FIFO head holds a result.
- `res_ready`  in  1  consumer accepts the head.
- `res_sum`  out  4  result bits [3:0].
- `res_cout_1`  out  1  result weight-16 bit.
- `res_cout_2`  out  1  result weight-32 bit.
- `res_id`  out  `IDW`  requester that produced the head result.
- `busy`  out  1  FIFO non-empty or any `req_valid` high.

## Operation

**Result definition**
- Value = `in1 + in2 + in3 + cin`, range 0..46.
- Encoded as `32*res_cout_2 + 16*res_cout_1 + res_sum`.
- `res_cout_1` and `res_cout_2` are never both 1.

**State**
- `rr_ptr`: `IDW` bits.
- FIFO: 2 entries, each `{sum[3:0], cout_1, cout_2, id}`.
- `count`: 0..2.
- `rd_ptr` and `wr_ptr`: 1 bit each.

**Grant**
- `space` = (`count` < 2).
- Winner = first i with `req_valid[i]` = 1, searching `rr_ptr`, `rr_ptr+1`, … modulo `NREQ`.
- `req_ready[winner]` = `space`; every other `req_ready` bit is 0.
- `req_ready` is combinational from `req_valid`, `rr_ptr` and `count`. It never depends on `res_ready`: there is no full-FIFO bypass.

**Accept (push)**
- Occurs when `req_valid[i]` and `req_ready[i]` are both 1.
- The winner's operands are muxed into the shared adder.
- The adder result and ID i are written to FIFO `[wr_ptr]`; `wr_ptr` toggles.
- `rr_ptr` <= (i+1) mod `NREQ`.

**Pointer rules**
- `rr_ptr` advances only on accept.
- With no accept, `rr_ptr` holds, so a stalled grant stays with the same requester.

**Pop**
- Occurs when `res_valid` and `res_ready` are both 1; `rd_ptr` toggles.
- Push and pop in the same cycle leave `count` unchanged.

**Output drive**
- `res_*` are driven from FIFO `[rd_ptr]`.
- When `count` = 0, `res_sum`, `res_cout_1`, `res_cout_2` and `res_id` are forced to 0.

**Requester protocol**
- Once `req_valid[i]` is asserted, requester i holds `req_valid[i]` and its operands stable until accepted.
- The block's behaviour is unspecified if a requester violates this.

**Reset**
- Set: `count` = 0, both FIFO pointers = 0, `rr_ptr` = 0.
- Reset overrides any push or pop in the same cycle.
- Mid-operation reset discards all buffered results.

## Timing
- Grant and adder evaluation are combinational in the accept cycle.
- Latency: an operation accepted at edge k has `res_valid` = 1 after edge k, provided the FIFO was empty.
- Throughput: 1 operation per cycle while `res_ready` is held high.
- Backpressure:
  - With `res_ready` low, at most 2 accepts complete.
  - On the first cycle after the second accept, `req_ready` = 0 for all requesters.
  - `req_ready` returns 1 in the first cycle after a pop.
- Fairness: a continuously valid requester is accepted within `NREQ` accepts.
- Reset values:
  - During reset: `req_ready` = 0.
  - After reset: `res_valid` = 0 and `res_sum`/`res_cout_1`/`res_cout_2`/`res_id` = 0.
  - `busy` follows its definition (= OR of `req_valid` while the FIFO is empty).
- No combinational path from `res_ready` to any output other than through registered state.

## Test plan
- Single operation: requester 2 sends `in1=15, in2=15, in3=15, cin=1`. Required: accepted in one cycle, then `res_sum=14, res_cout_1=0, res_cout_2=1, res_id=2` one cycle later.
- Round-robin: all 4 requesters valid continuously, `res_ready=1`. Required: `res_id` sequence 0,1,2,3,0,1,…; each requester gets exactly 1 accept per 4 cycles.
- Backpressure: `res_ready=0`, requesters 0 and 1 valid. Required: two accepts, then all `req_ready=0`; the FIFO holds IDs 0 and 1 in order. With `res_ready=1`, they drain 0 then 1 and the accepts resume.
- Simultaneous push/pop with `count=1`: `count` stays 1, ordering is preserved, and no entry is lost or duplicated.
- Reset mid-stream: assert `rst` with `count=2` and requesters valid. Required after the edge: `res_valid=0`, `count=0`, `rr_ptr=0`, and the next accept goes to the lowest valid ID.
- Exhaustive arithmetic: all 2^13 operand and `cin` combinations through requester 0. Every result equals `in1+in2+in3+cin` in the encoding above.
